fifo_modport: RTL and testbench
===============================

# fifo_modport

Single-clock 32-entry x 32-bit FIFO with programmable almost-full/almost-empty thresholds, overflow/underflow pulses, occupancy levels and wrapping transfer counters. It is the synchronous-FIFO block driven and observed by the FIFO verification environment's driver/monitor modports, and sits between a producer and a consumer sharing one clock domain.

## Interface
- DATA_WIDTH, 32, word width
- DEPTH, 32, number of entries (power of two)
- ADDR_WIDTH, 5, log2(DEPTH)
- wclk  input  1  single clock; write and read sides both use it; all logic on rising edge
- sw_rst  input  1  reset, synchronous, active-high
- mem_rst  input  1  synchronous active-high clear of storage array only
- wdata  input  32  write data
- write_enable  input  1  write request
- afull_value  input  5  almost-full threshold
- wfull  output  1  FIFO full
- wr_almost_ful  output  1  occupancy >= afull_value
- overflow  output  1  one-cycle pulse: write rejected
- fifo_write_count  output  6  accepted writes, mod 64
- wr_level  output  6  free entries (DEPTH - occupancy)
- read_data  output  32  registered read data
- read_enable  input  1  read request
- aempty_value  input  5  almost-empty threshold
- rdempty  output  1  FIFO empty
- rd_almost_empty  output  1  occupancy <= aempty_value
- underflow  output  1  one-cycle pulse: read rejected
- fifo_read_count  output  6  accepted reads, mod 64
- rd_level  output  6  occupancy (0..32)

## Operation
- State: wptr, rptr (5-bit, wrap 31->0), occupancy count (6-bit, 0..32), two 6-bit transfer counters.
- Write accepted iff write_enable && !wfull: mem[wptr] <= wdata, wptr++, fifo_write_count++.
- Read accepted iff read_enable && !rdempty: read_data <= mem[rptr], rptr++, fifo_read_count++.
- Acceptance uses flags of the current cycle (pre-edge state). Simultaneous read+write: each judged independently; when full, read accepted, write rejected; when empty, write accepted, read rejected. Occupancy += wr_acc - rd_acc.
- wfull = (occupancy == 32); rdempty = (occupancy == 0); wr_almost_ful = (occupancy >= afull_value); rd_almost_empty = (occupancy <= aempty_value); wr_level = 32 - occupancy; rd_level = occupancy. All combinational from registered occupancy and threshold inputs.
- overflow registered: high for the cycle after an edge where write_enable && wfull; underflow likewise for read_enable && rdempty.
- read_data holds its value when no read is accepted.
- Transfer counters wrap 63->0 silently.
- mem_rst: all 32 entries cleared to 0 at the edge; pointers, counts, flags, read_data unchanged; a write in the same cycle is overridden by the clear (entry stays 0, pointer still advances).
- sw_rst: wptr, rptr, occupancy, both counters, overflow, underflow, read_data -> 0; any write/read in that cycle discarded; memory contents untouched. sw_rst has priority over all other activity.

## Timing
- Reset values: wfull 0, rdempty 1, rd_almost_empty 1, wr_almost_ful 1 only if afull_value == 0, overflow 0, underflow 0, counts 0, wr_level 32, rd_level 0, read_data 0.
- Write at edge N: rdempty falls, rd_level increments immediately after edge N.
- Read accepted at edge N: read_data valid after edge N (1-cycle latency from read_enable sample).
- Write then read of same word: earliest read_enable sampled at edge N+1.
- Threshold input changes affect almost flags combinationally, same cycle.

## Structure
- Package fifo_pkg: DATA_WIDTH, DEPTH, ADDR_WIDTH, LEVEL_WIDTH (6) constants.
- One sub-module fifo_mem: 32x32 array, synchronous write port, synchronous registered read port, synchronous clear input.
- Top holds pointers, occupancy, counters, flag logic, error pulses.

## Test plan
- sw_rst 1 cycle -> rdempty=1, wfull=0, wr_level=32, rd_level=0, counts=0, read_data=0.
- Write 0x00..0x1F (32 words), afull_value=28 -> wr_almost_ful rises after 28th write, wfull after 32nd; 33rd write -> overflow=1 one cycle, fifo_write_count=32, data unchanged.
- Read 32 words -> read_data 0x00..0x1F in order, 1-cycle latency; 33rd read -> underflow=1 one cycle, read_data holds 0x1F.
- Full FIFO, write_enable+read_enable same cycle -> read accepted, overflow=1, rd_level=31.
- 70 write/read pairs -> fifo_write_count and fifo_read_count wrap to 6, pointer wrap preserves data order.
- sw_rst with 10 entries stored and read_enable high -> no read, rd_level=0, rdempty=1 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared sizing constants for the single-clock FIFO and its storage array.
//   DATA_WIDTH  : word width
//   DEPTH       : number of entries (power of two)
//   ADDR_WIDTH  : pointer width, log2(DEPTH)
//   LEVEL_WIDTH : width of occupancy/level/count values (holds 0..DEPTH)
package fifo_pkg;

   localparam int unsigned DATA_WIDTH  = 32;
   localparam int unsigned DEPTH       = 32;
   localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH);
   localparam int unsigned LEVEL_WIDTH = ADDR_WIDTH + 1;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//   DEPTH x DATA_WIDTH storage array with a synchronous write port, a registered
//   synchronous read port and a synchronous whole-array clear.
//   wclk    : clock, rising edge
//   sw_rst  : synchronous active-high reset of the read register only
//   clear   : zero every entry at the edge; overrides a same-cycle write
//   wr_en   : write wr_data into entry wr_addr
//   rd_en   : load rd_data from entry rd_addr (pre-edge contents)
//   rd_data : registered read data, holds when rd_en is low
module fifo_mem
   import fifo_pkg::*;
(
   input  logic                  wclk,
   input  logic                  sw_rst,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Storage is deliberately not touched by sw_rst; only clear zeroes it.
   always_ff @(posedge wclk) begin
      if (clear) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge wclk) begin
      if (sw_rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_modport.sv
// fifo_modport
//   Single-clock FIFO with programmable almost-full/almost-empty thresholds,
//   overflow/underflow pulses, occupancy levels and wrapping transfer counters.
//   wclk             : clock for both sides, rising edge
//   sw_rst           : synchronous active-high reset of control state and read_data
//   mem_rst          : synchronous active-high clear of the storage array only
//   wdata            : write data
//   write_enable     : write request, accepted when not full
//   afull_value      : almost-full threshold (occupancy >= afull_value)
//   wfull            : FIFO full
//   wr_almost_ful    : almost-full flag
//   overflow         : one-cycle pulse after a rejected write
//   fifo_write_count : accepted writes, mod 2**LEVEL_WIDTH
//   wr_level         : free entries
//   read_data        : registered read data
//   read_enable      : read request, accepted when not empty
//   aempty_value     : almost-empty threshold (occupancy <= aempty_value)
//   rdempty          : FIFO empty
//   rd_almost_empty  : almost-empty flag
//   underflow        : one-cycle pulse after a rejected read
//   fifo_read_count  : accepted reads, mod 2**LEVEL_WIDTH
//   rd_level         : occupancy
module fifo_modport
   import fifo_pkg::*;
(
   input  logic                   wclk,
   input  logic                   sw_rst,
   input  logic                   mem_rst,
   input  logic [DATA_WIDTH-1:0]  wdata,
   input  logic                   write_enable,
   input  logic [ADDR_WIDTH-1:0]  afull_value,
   output logic                   wfull,
   output logic                   wr_almost_ful,
   output logic                   overflow,
   output logic [LEVEL_WIDTH-1:0] fifo_write_count,
   output logic [LEVEL_WIDTH-1:0] wr_level,
   output logic [DATA_WIDTH-1:0]  read_data,
   input  logic                   read_enable,
   input  logic [ADDR_WIDTH-1:0]  aempty_value,
   output logic                   rdempty,
   output logic                   rd_almost_empty,
   output logic                   underflow,
   output logic [LEVEL_WIDTH-1:0] fifo_read_count,
   output logic [LEVEL_WIDTH-1:0] rd_level
);

   localparam logic [LEVEL_WIDTH-1:0] FullLevel = LEVEL_WIDTH'(DEPTH);

   logic [ADDR_WIDTH-1:0]  wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0]  rptr_q, rptr_d;
   logic [LEVEL_WIDTH-1:0] occ_q, occ_d;
   logic [LEVEL_WIDTH-1:0] wcnt_q, wcnt_d;
   logic [LEVEL_WIDTH-1:0] rcnt_q, rcnt_d;
   logic                   overflow_q, overflow_d;
   logic                   underflow_q, underflow_d;
   logic                   wr_acc, rd_acc;

   // Acceptance is judged from pre-edge flags, so a full FIFO still takes a read
   // (and rejects the write) and an empty FIFO still takes a write.
   assign wr_acc = write_enable && !wfull;
   assign rd_acc = read_enable && !rdempty;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      occ_d       = occ_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      overflow_d  = write_enable && wfull;
      underflow_d = read_enable && rdempty;
      if (wr_acc) begin
         wptr_d = wptr_q + 1'b1;
         wcnt_d = wcnt_q + 1'b1;
      end
      if (rd_acc) begin
         rptr_d = rptr_q + 1'b1;
         rcnt_d = rcnt_q + 1'b1;
      end
      occ_d = occ_q + LEVEL_WIDTH'(wr_acc) - LEVEL_WIDTH'(rd_acc);
   end

   always_ff @(posedge wclk) begin
      if (sw_rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         occ_q       <= '0;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         occ_q       <= occ_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // sw_rst outranks everything, including the array clear and any transfer.
   fifo_mem u_mem (
      .wclk    (wclk),
      .sw_rst  (sw_rst),
      .clear   (mem_rst && !sw_rst),
      .wr_en   (wr_acc && !sw_rst),
      .wr_addr (wptr_q),
      .wr_data (wdata),
      .rd_en   (rd_acc && !sw_rst),
      .rd_addr (rptr_q),
      .rd_data (read_data)
   );

   assign wfull            = (occ_q == FullLevel);
   assign rdempty          = (occ_q == '0);
   assign wr_almost_ful    = (occ_q >= {1'b0, afull_value});
   assign rd_almost_empty  = (occ_q <= {1'b0, aempty_value});
   assign wr_level         = FullLevel - occ_q;
   assign rd_level         = occ_q;
   assign overflow         = overflow_q;
   assign underflow        = underflow_q;
   assign fifo_write_count = wcnt_q;
   assign fifo_read_count  = rcnt_q;

endmodule

// File: tb/tb_fifo_modport.sv
// tb_fifo_modport
//   Directed plus randomized stimulus against a queue-based reference model.
module tb_fifo_modport;

   logic        wclk = 1'b0;
   logic        sw_rst = 1'b0;
   logic        mem_rst = 1'b0;
   logic [31:0] wdata = '0;
   logic        write_enable = 1'b0;
   logic [4:0]  afull_value = 5'd28;
   logic        wfull;
   logic        wr_almost_ful;
   logic        overflow;
   logic [5:0]  fifo_write_count;
   logic [5:0]  wr_level;
   logic [31:0] read_data;
   logic        read_enable = 1'b0;
   logic [4:0]  aempty_value = 5'd2;
   logic        rdempty;
   logic        rd_almost_empty;
   logic        underflow;
   logic [5:0]  fifo_read_count;
   logic [5:0]  rd_level;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [31:0] q[$];
   int          m_wcnt = 0;
   int          m_rcnt = 0;
   logic        m_ov = 1'b0;
   logic        m_un = 1'b0;
   logic [31:0] m_rd = '0;

   always #5 wclk = ~wclk;

   fifo_modport dut (
      .wclk             (wclk),
      .sw_rst           (sw_rst),
      .mem_rst          (mem_rst),
      .wdata            (wdata),
      .write_enable     (write_enable),
      .afull_value      (afull_value),
      .wfull            (wfull),
      .wr_almost_ful    (wr_almost_ful),
      .overflow         (overflow),
      .fifo_write_count (fifo_write_count),
      .wr_level         (wr_level),
      .read_data        (read_data),
      .read_enable      (read_enable),
      .aempty_value     (aempty_value),
      .rdempty          (rdempty),
      .rd_almost_empty  (rd_almost_empty),
      .underflow        (underflow),
      .fifo_read_count  (fifo_read_count),
      .rd_level         (rd_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("wfull", 32'(wfull), 32'(n == 32));
      chk("rdempty", 32'(rdempty), 32'(n == 0));
      chk("wr_almost_ful", 32'(wr_almost_ful), 32'(n >= int'(afull_value)));
      chk("rd_almost_empty", 32'(rd_almost_empty), 32'(n <= int'(aempty_value)));
      chk("wr_level", 32'(wr_level), 32'(32 - n));
      chk("rd_level", 32'(rd_level), 32'(n));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
      chk("fifo_write_count", 32'(fifo_write_count), 32'(m_wcnt % 64));
      chk("fifo_read_count", 32'(fifo_read_count), 32'(m_rcnt % 64));
      chk("read_data", read_data, m_rd);
   endtask

   // Apply one cycle of stimulus, advance the model at the edge, then check.
   task automatic cycle(input logic we, input logic [31:0] wd, input logic re,
                        input logic rst, input logic mrst);
      bit full, empty;
      write_enable = we;
      wdata        = wd;
      read_enable  = re;
      sw_rst       = rst;
      mem_rst      = mrst;
      @(posedge wclk);
      full  = (q.size() == 32);
      empty = (q.size() == 0);
      if (rst) begin
         q.delete();
         m_wcnt = 0;
         m_rcnt = 0;
         m_ov   = 1'b0;
         m_un   = 1'b0;
         m_rd   = '0;
      end else begin
         m_ov = we && full;
         m_un = re && empty;
         if (re && !empty) begin
            m_rd = q.pop_front();
            m_rcnt++;
         end
         if (we && !full) begin
            q.push_back(wd);
            m_wcnt++;
         end
         if (mrst) begin
            foreach (q[i]) q[i] = '0;
         end
      end
      #1;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      sw_rst       = 1'b0;
      mem_rst      = 1'b0;
      check_all();
   endtask

   initial begin
      // Reset
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("reset_rdempty", 32'(rdempty), 32'd1);
      chk("reset_wr_level", 32'(wr_level), 32'd32);

      // Fill with 0x00..0x1F, then one rejected write
      afull_value  = 5'd28;
      aempty_value = 5'd2;
      for (int i = 0; i < 32; i++) begin
         cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
         if (i == 26) chk("afull_below", 32'(wr_almost_ful), 32'd0);
         if (i == 27) chk("afull_at_28", 32'(wr_almost_ful), 32'd1);
      end
      chk("wfull_after_32", 32'(wfull), 32'd1);
      cycle(1'b1, 32'hdead_beef, 1'b0, 1'b0, 1'b0);
      chk("overflow_pulse", 32'(overflow), 32'd1);
      chk("wcount_32", 32'(fifo_write_count), 32'd32);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("overflow_drops", 32'(overflow), 32'd0);

      // Threshold changes act combinationally
      afull_value = 5'd0;
      #1;
      chk("afull_comb", 32'(wr_almost_ful), 32'd1);
      aempty_value = 5'd31;
      #1;
      chk("aempty_comb_full", 32'(rd_almost_empty), 32'd0);
      afull_value  = 5'd28;
      aempty_value = 5'd2;

      // Drain, then one rejected read
      for (int i = 0; i < 32; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
         chk("drain_order", read_data, 32'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("underflow_pulse", 32'(underflow), 32'd1);
      chk("rd_hold", read_data, 32'h1f);

      // Full with simultaneous write+read
      for (int i = 0; i < 32; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h5555, 1'b1, 1'b0, 1'b0);
      chk("full_rw_level", 32'(rd_level), 32'd31);
      chk("full_rw_ovf", 32'(overflow), 32'd1);
      chk("full_rw_data", read_data, 32'h100);

      // Empty with simultaneous write+read
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
      chk("empty_rw_unf", 32'(underflow), 32'd1);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("empty_rw_data", read_data, 32'h77);

      // 70 write/read pairs wrap the counters and pointers
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 70; i++) begin
         cycle(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
         chk("pair_data", read_data, 32'h1000 + 32'(i));
      end
      chk("wcount_wrap", 32'(fifo_write_count), 32'd6);
      chk("rcount_wrap", 32'(fifo_read_count), 32'd6);

      // sw_rst with 10 entries stored and read requested
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      chk("swrst_level", 32'(rd_level), 32'd0);
      chk("swrst_empty", 32'(rdempty), 32'd1);
      chk("swrst_rdata", read_data, 32'd0);

      // mem_rst clears stored words and overrides a same-cycle write
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h3004, 1'b0, 1'b0, 1'b1);
      chk("mrst_level", 32'(rd_level), 32'd5);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("mrst_data", read_data, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) afull_value = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) aempty_value = 5'($urandom_range(0, 31));
         cycle(1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 9) < 5),
               1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
